// File: rtl/pipeline_run_controller.sv
// Run/step/drain sequencer for the 5-stage MIPS debug front-end: loads program
// words from a byte stream, gates the pipeline enable and reports HALT completion.
module pipeline_run_controller #(
  parameter int              SIZE         = 32,
  parameter int              ADDR_WIDTH   = 6,
  parameter logic [SIZE-1:0] HALT_WORD    = 32'hFFFFFFFF,
  parameter int              DRAIN_CYCLES = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cmd_valid,
  input  logic [2:0]            i_cmd,
  input  logic [ADDR_WIDTH:0]   i_load_count,
  input  logic                  i_byte_valid,
  input  logic [7:0]            i_byte,
  input  logic [SIZE-1:0]       i_if_id_instr,
  input  logic [SIZE-1:0]       i_pc,
  input  logic                  i_bp_en,
  input  logic [SIZE-1:0]       i_bp_pc,
  output logic                  o_pipe_en,
  output logic                  o_prog_reset,
  output logic                  o_inst_write_enable,
  output logic [ADDR_WIDTH-1:0] o_write_addr,
  output logic [SIZE-1:0]       o_write_data,
  output logic                  o_cmd_ready,
  output logic                  o_done,
  output logic [2:0]            o_state,
  output logic [31:0]           o_cycle_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_STEP  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [2:0] C_LOAD       = 3'd1;
  localparam logic [2:0] C_RUN        = 3'd2;
  localparam logic [2:0] C_STEP       = 3'd3;
  localparam logic [2:0] C_HALT       = 3'd4;
  localparam logic [2:0] C_PROG_RESET = 3'd5;

  localparam logic [7:0] DRAIN_INIT = 8'(DRAIN_CYCLES);

  logic [2:0]            r_state;
  logic                  r_first_run;
  logic [7:0]            r_drain_cnt;
  logic [ADDR_WIDTH:0]   r_words_left;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [1:0]            r_byte_cnt;
  logic [SIZE-9:0]       r_shift;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [SIZE-1:0]       r_wdata;
  logic                  r_prog_reset;
  logic [31:0]           r_cycle_count;

  logic w_ready;
  logic w_accept;
  logic w_halt_cmd;
  logic w_halt_word;
  logic w_bp_hit;
  logic w_pipe_en;

  assign w_ready     = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_accept    = i_cmd_valid && w_ready;
  assign w_halt_cmd  = i_cmd_valid && (i_cmd == C_HALT) &&
                       ((r_state == S_RUN) || (r_state == S_STEP) || (r_state == S_DRAIN));
  assign w_halt_word = (i_if_id_instr == HALT_WORD);
  // First RUN cycle ignores the breakpoint so a resume from the stop PC advances.
  assign w_bp_hit    = (r_state == S_RUN) && i_bp_en && (i_pc == i_bp_pc) && !r_first_run;
  assign w_pipe_en   = (r_state == S_STEP) || (r_state == S_DRAIN) ||
                       ((r_state == S_RUN) && (!w_bp_hit || w_halt_word));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_first_run   <= 1'b0;
      r_drain_cnt   <= '0;
      r_words_left  <= '0;
      r_addr        <= '0;
      r_byte_cnt    <= '0;
      r_shift       <= '0;
      r_we          <= 1'b0;
      r_waddr       <= '0;
      r_wdata       <= '0;
      r_prog_reset  <= 1'b0;
      r_cycle_count <= '0;
    end else begin
      r_we         <= 1'b0;
      r_prog_reset <= 1'b0;
      if (w_pipe_en && (r_cycle_count != '1)) r_cycle_count <= r_cycle_count + 32'd1;

      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            case (i_cmd)
              C_LOAD: begin
                r_state      <= (i_load_count == '0) ? S_IDLE : S_LOAD;
                r_words_left <= i_load_count;
                r_addr       <= '0;
                r_byte_cnt   <= '0;
              end
              C_RUN: if (r_state == S_IDLE) begin
                r_state     <= S_RUN;
                r_first_run <= 1'b1;
              end
              C_STEP: if (r_state == S_IDLE) r_state <= S_STEP;
              C_PROG_RESET: begin
                r_prog_reset  <= 1'b1;
                r_cycle_count <= '0;
                r_state       <= S_IDLE;
              end
              default: ;
            endcase
          end
        end
        S_LOAD: begin
          // Last word's strobe is out this cycle: follow it with the PC reset pulse.
          if (r_we && (r_words_left == '0)) begin
            r_prog_reset  <= 1'b1;
            r_cycle_count <= '0;
            r_state       <= S_IDLE;
          end else if (i_byte_valid && (r_words_left != '0)) begin
            r_shift    <= {r_shift[SIZE-17:0], i_byte};
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_we         <= 1'b1;
              r_waddr      <= r_addr;
              r_wdata      <= {r_shift, i_byte};
              r_addr       <= r_addr + 1'b1;
              r_words_left <= r_words_left - 1'b1;
            end
          end
        end
        S_RUN: begin
          r_first_run <= 1'b0;
          if (w_halt_cmd) begin
            r_state <= S_IDLE;
          end else if (w_halt_word) begin
            r_state     <= S_DRAIN;
            r_drain_cnt <= DRAIN_INIT;
          end else if (w_bp_hit) begin
            r_state <= S_IDLE;
          end
        end
        S_STEP: begin
          if (!w_halt_cmd && w_halt_word) begin
            r_state     <= S_DRAIN;
            r_drain_cnt <= DRAIN_INIT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (w_halt_cmd) r_state <= S_IDLE;
          else if (r_drain_cnt <= 8'd1) r_state <= S_DONE;
          else r_drain_cnt <= r_drain_cnt - 8'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_pipe_en           = w_pipe_en;
  assign o_prog_reset        = r_prog_reset;
  assign o_inst_write_enable = r_we;
  assign o_write_addr        = r_waddr;
  assign o_write_data        = r_wdata;
  assign o_cmd_ready         = w_ready;
  assign o_done              = (r_state == S_DONE);
  assign o_state             = r_state;
  assign o_cycle_count       = r_cycle_count;

endmodule

// File: tb/tb_pipeline_run_controller.sv
// Directed bench for pipeline_run_controller: load, run-to-halt, breakpoints,
// stepping, command conflicts and reset during load.
module tb_pipeline_run_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd = 3'd0;
  logic [6:0]  load_count = 7'd0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_in = 8'd0;
  logic [31:0] if_id_instr = 32'd0;
  logic [31:0] pc_in = 32'd0;
  logic        bp_en = 1'b0;
  logic [31:0] bp_pc = 32'd0;
  logic        pipe_en, prog_reset, we, cmd_ready, done;
  logic [5:0]  waddr;
  logic [31:0] wdata, cycle_count;
  logic [2:0]  state;

  int n_checks = 0;
  int n_fail   = 0;

  pipeline_run_controller dut (
    .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
    .i_load_count(load_count), .i_byte_valid(byte_valid), .i_byte(byte_in),
    .i_if_id_instr(if_id_instr), .i_pc(pc_in), .i_bp_en(bp_en), .i_bp_pc(bp_pc),
    .o_pipe_en(pipe_en), .o_prog_reset(prog_reset), .o_inst_write_enable(we),
    .o_write_addr(waddr), .o_write_data(wdata), .o_cmd_ready(cmd_ready),
    .o_done(done), .o_state(state), .o_cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] c, input logic [6:0] n);
    cmd_valid = 1'b1; cmd = c; load_count = n;
    cyc();
    cmd_valid = 1'b0; cmd = 3'd0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    #1;
    n_checks++;
    if ({state, pipe_en, prog_reset, we, waddr, wdata, done, cycle_count, cmd_ready} !==
        {3'd0, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 32'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_outputs state=%0d en=%b pr=%b we=%b addr=%0d data=%h done=%b cnt=%0d rdy=%b",
               state, pipe_en, prog_reset, we, waddr, wdata, done, cycle_count, cmd_ready);
    end
  endtask

  task automatic test_load;
    logic [7:0] bytes [8];
    int wcnt, pcnt, encnt;
    bytes = '{8'h20, 8'h01, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
    wcnt = 0; pcnt = 0; encnt = 0;
    issue(3'd1, 7'd2);
    n_checks++;
    if (state !== 3'd1) begin n_fail++; $display("FAIL load_enter state=%0d exp=1", state); end
    for (int k = 0; k < 14; k++) begin
      byte_valid = (k < 8);
      if (k < 8) byte_in = bytes[k];
      #1;
      if (we === 1'b1) begin
        n_checks++;
        if (wcnt == 0 && (waddr !== 6'd0 || wdata !== 32'h20010005)) begin
          n_fail++; $display("FAIL load_word0 addr=%0d data=%h exp 0/20010005", waddr, wdata);
        end else if (wcnt == 1 && (waddr !== 6'd1 || wdata !== 32'h0)) begin
          n_fail++; $display("FAIL load_word1 addr=%0d data=%h exp 1/00000000", waddr, wdata);
        end
        wcnt++;
      end
      if (prog_reset === 1'b1) pcnt++;
      if (pipe_en === 1'b1) encnt++;
      cyc();
    end
    byte_valid = 1'b0;
    n_checks++;
    if (wcnt != 2) begin n_fail++; $display("FAIL load_strobes got=%0d exp=2", wcnt); end
    n_checks++;
    if (pcnt != 1) begin n_fail++; $display("FAIL load_prog_reset got=%0d exp=1", pcnt); end
    n_checks++;
    if (encnt != 0 || state !== 3'd0) begin
      n_fail++; $display("FAIL load_end en_cycles=%0d state=%0d exp 0/0", encnt, state);
    end
  endtask

  task automatic test_run_halt;
    int encnt;
    encnt = 0;
    issue(3'd2, 7'd0);
    for (int k = 0; k < 14; k++) begin
      if_id_instr = (k == 2) ? 32'hFFFFFFFF : 32'h0;
      #1;
      if (pipe_en === 1'b1) encnt++;
      cyc();
    end
    if_id_instr = 32'h0;
    n_checks++;
    if (encnt != 7) begin n_fail++; $display("FAIL run_halt_enables got=%0d exp=7", encnt); end
    n_checks++;
    if (done !== 1'b1 || state !== 3'd5) begin
      n_fail++; $display("FAIL run_halt_done done=%b state=%0d exp 1/5", done, state);
    end
    n_checks++;
    if (cycle_count !== 32'd7) begin n_fail++; $display("FAIL run_halt_count got=%0d exp=7", cycle_count); end
  endtask

  task automatic test_done_conflicts;
    issue(3'd2, 7'd0);
    n_checks++;
    if (state !== 3'd5 || pipe_en !== 1'b0 || done !== 1'b1) begin
      n_fail++; $display("FAIL run_in_done state=%0d en=%b done=%b exp 5/0/1", state, pipe_en, done);
    end
    issue(3'd5, 7'd0);
    n_checks++;
    if (prog_reset !== 1'b1 || state !== 3'd0 || done !== 1'b0 || cycle_count !== 32'd0) begin
      n_fail++; $display("FAIL prog_reset_in_done pr=%b state=%0d done=%b cnt=%0d exp 1/0/0/0",
                         prog_reset, state, done, cycle_count);
    end
    cyc();
    n_checks++;
    if (prog_reset !== 1'b0) begin n_fail++; $display("FAIL prog_reset_width pr=%b exp=0", prog_reset); end
  endtask

  task automatic test_step;
    int bad;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      issue(3'd3, 7'd0);
      if (state !== 3'd3 || pipe_en !== 1'b1) bad++;
      cyc();
      if (state !== 3'd0 || pipe_en !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL step_pulses bad_cycles=%0d exp=0", bad); end
    n_checks++;
    if (cycle_count !== 32'd3) begin n_fail++; $display("FAIL step_count got=%0d exp=3", cycle_count); end
  endtask

  task automatic test_breakpoint;
    int pc, stop_pc, stalls;
    pc = 3; stop_pc = -1; stalls = 0;
    bp_en = 1'b1; bp_pc = 32'd5;
    pc_in = 32'(pc);
    issue(3'd2, 7'd0);
    for (int k = 0; k < 8; k++) begin
      pc_in = 32'(pc);
      #1;
      if (state === 3'd2 && pipe_en === 1'b0 && stop_pc < 0) stop_pc = pc;
      if (pipe_en === 1'b1) pc++;
      cyc();
    end
    n_checks++;
    if (stop_pc != 5 || pc != 5 || state !== 3'd0) begin
      n_fail++; $display("FAIL bp_stop stop_pc=%0d pc=%0d state=%0d exp 5/5/0", stop_pc, pc, state);
    end
    pc_in = 32'(pc);
    issue(3'd2, 7'd0);
    for (int k = 0; k < 4; k++) begin
      pc_in = 32'(pc);
      #1;
      if (pipe_en === 1'b1) pc++;
      else stalls++;
      cyc();
    end
    n_checks++;
    if (pc != 9 || stalls != 0 || state !== 3'd2) begin
      n_fail++; $display("FAIL bp_resume pc=%0d stalls=%0d state=%0d exp 9/0/2", pc, stalls, state);
    end
    pc_in = 32'(pc);
    issue(3'd4, 7'd0);
    n_checks++;
    if (state !== 3'd0 || pipe_en !== 1'b0) begin
      n_fail++; $display("FAIL halt_in_run state=%0d en=%b exp 0/0", state, pipe_en);
    end
    bp_en = 1'b0;
  endtask

  task automatic test_run_during_load;
    issue(3'd1, 7'd1);
    cmd_valid = 1'b1; cmd = 3'd2; byte_valid = 1'b1; byte_in = 8'hAA;
    cyc();
    cmd_valid = 1'b0; cmd = 3'd0;
    n_checks++;
    if (state !== 3'd1 || pipe_en !== 1'b0) begin
      n_fail++; $display("FAIL run_in_load state=%0d en=%b exp 1/0", state, pipe_en);
    end
    byte_in = 8'hBB; cyc();
    byte_in = 8'hCC; cyc();
    byte_in = 8'hDD; cyc();
    byte_valid = 1'b0;
    n_checks++;
    if (we !== 1'b1 || waddr !== 6'd0 || wdata !== 32'hAABBCCDD) begin
      n_fail++; $display("FAIL load_single we=%b addr=%0d data=%h exp 1/0/aabbccdd", we, waddr, wdata);
    end
    cyc();
    n_checks++;
    if (prog_reset !== 1'b1 || we !== 1'b0 || state !== 3'd0) begin
      n_fail++; $display("FAIL load_single_end pr=%b we=%b state=%0d exp 1/0/0", prog_reset, we, state);
    end
  endtask

  task automatic test_reset_mid_load;
    int wcnt;
    wcnt = 0;
    issue(3'd1, 7'd1);
    byte_valid = 1'b1;
    byte_in = 8'h01; cyc();
    byte_in = 8'h02; cyc();
    rst = 1'b1; byte_in = 8'h03;
    cyc();
    n_checks++;
    if ({state, pipe_en, prog_reset, we, waddr, wdata, done, cycle_count, cmd_ready} !==
        {3'd0, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 32'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_mid_load state=%0d en=%b pr=%b we=%b addr=%0d data=%h done=%b cnt=%0d rdy=%b",
               state, pipe_en, prog_reset, we, waddr, wdata, done, cycle_count, cmd_ready);
    end
    rst = 1'b0; byte_in = 8'h04;
    for (int k = 0; k < 4; k++) begin
      if (we === 1'b1) wcnt++;
      cyc();
      byte_valid = 1'b0;
    end
    n_checks++;
    if (wcnt != 0 || state !== 3'd0) begin
      n_fail++; $display("FAIL reset_no_write strobes=%0d state=%0d exp 0/0", wcnt, state);
    end
    issue(3'd1, 7'd1);
    byte_valid = 1'b1;
    byte_in = 8'h11; cyc();
    byte_in = 8'h22; cyc();
    byte_in = 8'h33; cyc();
    byte_in = 8'h44; cyc();
    byte_valid = 1'b0;
    n_checks++;
    if (we !== 1'b1 || waddr !== 6'd0 || wdata !== 32'h11223344) begin
      n_fail++; $display("FAIL fresh_load we=%b addr=%0d data=%h exp 1/0/11223344", we, waddr, wdata);
    end
    cyc();
  endtask

  initial begin
    test_reset();
    test_load();
    test_run_halt();
    test_done_conflicts();
    test_step();
    test_breakpoint();
    test_run_during_load();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
